// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/micro-op sequencer for the 5-stage pipeline: load-use stalls, LM/SM expansion, memory freeze.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_sequencer #(
    parameter logic [3:0]  LW_OPCODE    = 4'b0100,
    parameter logic [3:0]  LM_OPCODE    = 4'b0110,
    parameter logic [3:0]  SM_OPCODE    = 4'b0111,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_busy,
    input  logic        br_taken,
    input  logic [3:0]  id_opcode,
    input  logic [2:0]  id_rs1,
    input  logic        id_rs1_used,
    input  logic [2:0]  id_rs2,
    input  logic        id_rs2_used,
    input  logic [7:0]  id_reg_list,
    input  logic [3:0]  ex_opcode,
    input  logic [2:0]  ex_rd,
    input  logic        ex_reg_wr_en,
    output logic [4:0]  stage_en,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        ms_active,
    output logic        ms_store,
    output logic [2:0]  ms_reg_idx,
    output logic [2:0]  ms_offset,
    output logic        ms_last,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned NREG    = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned STAGE_W = 5;
    localparam int unsigned PERF_W  = 16;

    localparam logic [STAGE_W-1:0] EN_ALL  = 5'b11111;
    localparam logic [STAGE_W-1:0] EN_LU   = 5'b00011;
    localparam logic [STAGE_W-1:0] EN_MS   = 5'b00111;
    localparam logic [STAGE_W-1:0] EN_NONE = 5'b00000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MULTI    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   list_q, list_d;
    logic [IDX_W-1:0]  offset_q, offset_d;
    logic              store_q, store_d;
    logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;

    logic              lu_hazard;
    logic              ms_entry;
    logic              list_last;
    logic [IDX_W-1:0]  low_idx;

    assign lu_hazard = (ex_opcode == LW_OPCODE) && ex_reg_wr_en &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));
    assign ms_entry  = ((id_opcode == LM_OPCODE) || (id_opcode == SM_OPCODE)) &&
                       (id_reg_list != '0);
    assign list_last = (list_q & (list_q - NREG'(1))) == '0;

    // Lowest set bit of the remaining register list
    always_comb begin
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            list_q   <= '0;
            offset_q <= '0;
            store_q  <= 1'b0;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            list_q   <= list_d;
            offset_q <= offset_d;
            store_q  <= store_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Next state and pipeline controls; reset forces the reset-value outputs immediately
    always_comb begin
        state_d     = state_q;
        list_d      = list_q;
        offset_d    = offset_q;
        store_d     = store_q;
        lu_cnt_d    = lu_cnt_q;
        stage_en    = EN_ALL;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        ms_active   = 1'b0;
        ms_store    = 1'b0;
        ms_reg_idx  = '0;
        ms_offset   = '0;
        ms_last     = 1'b0;

        if (!reset) begin
            stage_en = EN_ALL;
        end else if (mem_busy) begin
            stage_en = EN_NONE;
            if (state_q == MULTI) begin
                ms_store   = store_q;
                ms_reg_idx = low_idx;
                ms_offset  = offset_q;
            end
        end else if (br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            state_d     = RUN;
            list_d      = '0;
            offset_d    = '0;
            store_d     = 1'b0;
            lu_cnt_d    = '0;
        end else begin
            case (state_q)
                MULTI: begin
                    ms_active  = 1'b1;
                    ms_store   = store_q;
                    ms_reg_idx = low_idx;
                    ms_offset  = offset_q;
                    list_d     = list_q & (list_q - NREG'(1));
                    offset_d   = offset_q + IDX_W'(1);
                    if (list_last) begin
                        ms_last  = 1'b1;
                        stage_en = EN_ALL;
                        state_d  = RUN;
                    end else begin
                        stage_en = EN_MS;
                    end
                end
                LU_STALL: begin
                    stage_en    = EN_LU;
                    flush_id_ex = 1'b1;
                    if (lu_cnt_q <= CNT_W'(1)) begin
                        lu_cnt_d = '0;
                        state_d  = RUN;
                    end else begin
                        lu_cnt_d = lu_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (lu_hazard) begin
                        stage_en    = EN_LU;
                        flush_id_ex = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            lu_cnt_d = CNT_W'(STALL_CYCLES - 1);
                            state_d  = LU_STALL;
                        end
                    end else if (ms_entry) begin
                        list_d      = id_reg_list;
                        offset_d    = '0;
                        store_d     = (id_opcode == SM_OPCODE);
                        stage_en    = EN_MS;
                        flush_id_ex = 1'b1;
                        state_d     = MULTI;
                    end
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic              stall_ev;
    logic              flush_ev;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    assign flush_ev = !mem_busy && br_taken;
    assign stall_ev = !mem_busy && !br_taken &&
                      ((state_q == LU_STALL) || ((state_q == RUN) && lu_hazard));

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (flush_ev && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer: vector table plus hand-written multi-cycle sequences.
// DUT u1 uses STALL_CYCLES=1, u2 uses STALL_CYCLES=3 for the mid-stall reset case.
module tb_pipeline_hazard_sequencer;

    typedef struct {
        logic       busy;
        logic       br;
        logic [3:0] id_op;
        logic [2:0] rs1;
        logic       rs1_u;
        logic [2:0] rs2;
        logic       rs2_u;
        logic [7:0] list;
        logic [3:0] ex_op;
        logic [2:0] ex_rd;
        logic       ex_wr;
        logic [4:0] e_en;
        logic       e_fif;
        logic       e_fie;
        logic       e_act;
        logic       e_st;
        logic [2:0] e_idx;
        logic [2:0] e_off;
        logic       e_last;
    } vec_t;

    localparam logic [3:0] LW = 4'b0100;
    localparam logic [3:0] LM = 4'b0110;
    localparam logic [3:0] SM = 4'b0111;
    localparam logic [3:0] NOP = 4'b0000;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [15:0] EXP_STALLS  = 16'd4;
    localparam logic [15:0] EXP_FLUSHES = 16'd2;
`else
    localparam logic [15:0] EXP_STALLS  = 16'd0;
    localparam logic [15:0] EXP_FLUSHES = 16'd0;
`endif

    logic clk, reset, mem_busy, br_taken;
    logic [3:0] id_opcode, ex_opcode;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_used, id_rs2_used, ex_reg_wr_en;
    logic [7:0] id_reg_list;

    logic [4:0]  stage_en1, stage_en2;
    logic        fif1, fie1, act1, st1, last1;
    logic        fif2, fie2, act2, st2, last2;
    logic [2:0]  idx1, off1, idx2, off2;
    logic [15:0] scnt1, fcnt1, scnt2, fcnt2;
    logic [15:0] obs1;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_sequencer #(.STALL_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .mem_busy(mem_busy), .br_taken(br_taken),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_reg_list(id_reg_list),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_reg_wr_en(ex_reg_wr_en),
        .stage_en(stage_en1), .flush_if_id(fif1), .flush_id_ex(fie1),
        .ms_active(act1), .ms_store(st1), .ms_reg_idx(idx1), .ms_offset(off1),
        .ms_last(last1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    pipeline_hazard_sequencer #(.STALL_CYCLES(3)) u2 (
        .clk(clk), .reset(reset), .mem_busy(mem_busy), .br_taken(br_taken),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_reg_list(id_reg_list),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_reg_wr_en(ex_reg_wr_en),
        .stage_en(stage_en2), .flush_if_id(fif2), .flush_id_ex(fie2),
        .ms_active(act2), .ms_store(st2), .ms_reg_idx(idx2), .ms_offset(off2),
        .ms_last(last2), .stall_cnt(scnt2), .flush_cnt(fcnt2)
    );

    assign obs1 = {stage_en1, fif1, fie1, act1, st1, idx1, off1, last1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t vin(input logic [3:0] id_op, input logic [2:0] rs1, input logic rs1_u,
                                 input logic [2:0] rs2, input logic rs2_u, input logic [7:0] list,
                                 input logic [3:0] ex_op, input logic [2:0] ex_rd_i, input logic ex_wr);
        vec_t v;
        v.busy = 1'b0; v.br = 1'b0;
        v.id_op = id_op; v.rs1 = rs1; v.rs1_u = rs1_u; v.rs2 = rs2; v.rs2_u = rs2_u;
        v.list = list; v.ex_op = ex_op; v.ex_rd = ex_rd_i; v.ex_wr = ex_wr;
        v.e_en = 5'b11111; v.e_fif = 1'b0; v.e_fie = 1'b0; v.e_act = 1'b0; v.e_st = 1'b0;
        v.e_idx = 3'd0; v.e_off = 3'd0; v.e_last = 1'b0;
        return v;
    endfunction

    function automatic vec_t vexp(input vec_t vi, input logic [4:0] en, input logic fif, input logic fie,
                                  input logic act, input logic st, input logic [2:0] idx,
                                  input logic [2:0] off, input logic last);
        vec_t v;
        v = vi;
        v.e_en = en; v.e_fif = fif; v.e_fie = fie; v.e_act = act; v.e_st = st;
        v.e_idx = idx; v.e_off = off; v.e_last = last;
        return v;
    endfunction

    function automatic logic [15:0] expv(input vec_t v);
        return {v.e_en, v.e_fif, v.e_fie, v.e_act, v.e_st, v.e_idx, v.e_off, v.e_last};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mem_busy = v.busy; br_taken = v.br;
        id_opcode = v.id_op; id_rs1 = v.rs1; id_rs1_used = v.rs1_u;
        id_rs2 = v.rs2; id_rs2_used = v.rs2_u; id_reg_list = v.list;
        ex_opcode = v.ex_op; ex_rd = v.ex_rd; ex_reg_wr_en = v.ex_wr;
    endtask

    // Apply one vector for one cycle and compare u1 outputs mid-cycle
    task automatic run_vec(input string name, input vec_t v);
        drive(v);
        @(negedge clk);
        chk(name, obs1, expv(v));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[18];
        vec_t idle, haz, v;

        idle = vin(NOP, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, NOP, 3'd0, 1'b0);
        haz  = vexp(vin(NOP, 3'd3, 1'b1, 3'd0, 1'b0, 8'h00, LW, 3'd3, 1'b1),
                    5'b00011, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);

        tbl[0]  = idle;
        tbl[1]  = haz;
        tbl[2]  = vin(NOP, 3'd3, 1'b1, 3'd0, 1'b0, 8'h00, NOP, 3'd0, 1'b0);
        tbl[3]  = vin(NOP, 3'd3, 1'b0, 3'd0, 1'b0, 8'h00, LW, 3'd3, 1'b1);
        tbl[4]  = vexp(vin(NOP, 3'd3, 1'b0, 3'd3, 1'b1, 8'h00, LW, 3'd3, 1'b1),
                       5'b00011, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        tbl[5]  = vin(NOP, 3'd3, 1'b1, 3'd0, 1'b0, 8'h00, LW, 3'd3, 1'b0);
        tbl[6]  = vin(NOP, 3'd3, 1'b1, 3'd0, 1'b0, 8'h00, LM, 3'd3, 1'b1);
        tbl[7]  = vin(LM, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, NOP, 3'd0, 1'b0);
        tbl[8]  = vexp(vin(LM, 3'd0, 1'b0, 3'd0, 1'b0, 8'hA5, NOP, 3'd0, 1'b0),
                       5'b00111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        tbl[9]  = vexp(tbl[8], 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        tbl[10] = vexp(tbl[8], 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd1, 1'b0);
        tbl[11] = vexp(tbl[8], 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd2, 1'b0);
        tbl[12] = vexp(tbl[8], 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 3'd3, 1'b1);
        tbl[13] = idle;
        tbl[14] = vexp(vin(LM, 3'd1, 1'b1, 3'd0, 1'b0, 8'h0F, LW, 3'd1, 1'b1),
                       5'b00011, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        tbl[15] = vexp(vin(SM, 3'd0, 1'b0, 3'd0, 1'b0, 8'h80, NOP, 3'd0, 1'b0),
                       5'b00111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        tbl[16] = vexp(tbl[15], 5'b11111, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 3'd0, 1'b1);
        tbl[17] = idle;

        // Reset state
        reset = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", obs1, expv(idle));
        chk("reset_stall_cnt", scnt1, 16'd0);
        chk("reset_flush_cnt", fcnt1, 16'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Branch abort during the second micro-op of SM 8'hFF
        v = vexp(vin(SM, 3'd0, 1'b0, 3'd0, 1'b0, 8'hFF, NOP, 3'd0, 1'b0),
                 5'b00111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        run_vec("br_entry", v);
        run_vec("br_multi0", vexp(v, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0));
        v.br = 1'b1;
        run_vec("br_abort", vexp(v, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0));
        run_vec("br_after", idle);

        // Memory freeze mid-sequence of LM 8'h0F with an ignored branch
        v = vexp(vin(LM, 3'd0, 1'b0, 3'd0, 1'b0, 8'h0F, NOP, 3'd0, 1'b0),
                 5'b00111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        run_vec("mb_entry", v);
        run_vec("mb_multi0", vexp(v, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            v.busy = 1'b1;
            v.br = (i == 1);
            drive(v);
            @(negedge clk);
            chk($sformatf("mb_freeze_en%0d", i), 16'(stage_en1), 16'd0);
            chk($sformatf("mb_freeze_flush%0d", i), {14'd0, fif1, fie1}, 16'd0);
            chk($sformatf("mb_freeze_off%0d", i), {10'd0, idx1, off1}, {10'd0, 3'd1, 3'd1});
            @(posedge clk);
            #1;
        end
        v.busy = 1'b0;
        v.br = 1'b0;
        run_vec("mb_resume1", vexp(v, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 1'b0));
        run_vec("mb_resume2", vexp(v, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 1'b0));
        run_vec("mb_resume3", vexp(v, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'd3, 1'b1));
        run_vec("mb_after", idle);

        // Asynchronous reset in the middle of a 3-cycle load-use stall
        drive(haz);
        @(negedge clk);
        chk("ar_detect", 16'(stage_en2), 16'(5'b00011));
        @(posedge clk);
        #1;
        drive(idle);
        #1;
        chk("ar_lu_stall", {11'd0, stage_en2}, {11'd0, 5'b00011});
        chk("ar_lu_flush", 16'(fie2), 16'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_reset_en", 16'(stage_en2), 16'(5'b11111));
        chk("ar_reset_flush", 16'(fie2), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ar_after_run", 16'(stage_en2), 16'(5'b11111));
        @(posedge clk);
        #1;

        // Performance counters: four load-use stalls, two accepted branches
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("pc_haz%0d", i), haz);
            run_vec($sformatf("pc_clr%0d", i), idle);
        end
        v = vexp(idle, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        v.br = 1'b1;
        run_vec("pc_br0", v);
        run_vec("pc_br1", v);
        drive(idle);
        @(negedge clk);
        chk("perf_stall_cnt", scnt1, EXP_STALLS);
        chk("perf_flush_cnt", fcnt1, EXP_FLUSHES);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
